// File: rtl/seg_scan_ctrl.sv
// Synchronises the processor's 7-segment outputs, filters them for stability,
// captures the low/high digit patterns and multiplexes them onto two anodes.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV   = 1024,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       lsb_in,
    input  logic       disp_en,
    output logic [6:0] seg_out,
    output logic [1:0] an_out,
    output logic       frame_tick,
    output logic       valid_out,
    output logic [6:0] digit_lo,
    output logic [6:0] digit_hi
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] STAB_CAP  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [1:0]    AN_OFF    = {2{ACTIVE_LOW}};
    localparam logic [6:0]    SEG_OFF   = {7{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        BLANK   = 2'd0,
        SCAN_LO = 2'd1,
        SCAN_HI = 2'd2
    } state_t;

    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [7:0]    w_prev;
    logic [SW-1:0] stab_cnt;
    logic          cap;
    logic          got_lo;
    logic          got_hi;
    logic          got_lo_nxt;
    logic          got_hi_nxt;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;
    logic          lo_on;
    logic          hi_on;
    logic          tick_nxt;
    logic [6:0]    seg_true;
    logic [1:0]    an_nxt;
    logic [6:0]    seg_nxt;

    // Two-flop synchroniser for the asynchronous {digit flag, segments} bus
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {lsb_in, seg_in};
            sync2 <= sync1;
        end
    end

    // Stability counter: restarts on any change, saturates once captured
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_prev   <= '0;
            stab_cnt <= '0;
        end else begin
            w_prev <= sync2;
            if (sync2 != w_prev) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + SW'(1);
            end
        end
    end

    assign cap        = (sync2 == w_prev) && (stab_cnt == STAB_CAP);
    assign got_lo_nxt = got_lo | (cap & sync2[7]);
    assign got_hi_nxt = got_hi | (cap & ~sync2[7]);

    // Capture the stable pattern into the digit selected by the flag bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_lo  <= '0;
            digit_hi  <= '0;
            got_lo    <= 1'b0;
            got_hi    <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            if (cap && sync2[7]) begin
                digit_lo <= sync2[6:0];
            end
            if (cap && !sync2[7]) begin
                digit_hi <= sync2[6:0];
            end
            got_lo    <= got_lo_nxt;
            got_hi    <= got_hi_nxt;
            valid_out <= got_lo_nxt & got_hi_nxt;
        end
    end

    // Scan state, refresh counter and registered display drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            rcnt       <= '0;
            an_out     <= AN_OFF;
            seg_out    <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            rcnt       <= rcnt_nxt;
            an_out     <= an_nxt;
            seg_out    <= seg_nxt;
            frame_tick <= tick_nxt;
        end
    end

    // Next scan state plus anode/segment selection with a dead cycle at rcnt 0
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        tick_nxt  = 1'b0;
        lo_on     = disp_en && (state == SCAN_LO) && (rcnt != '0);
        hi_on     = disp_en && (state == SCAN_HI) && (rcnt != '0);

        if (!disp_en) begin
            state_nxt = BLANK;
            rcnt_nxt  = '0;
        end else begin
            case (state)
                BLANK: begin
                    state_nxt = SCAN_LO;
                    rcnt_nxt  = '0;
                end
                SCAN_LO: begin
                    if (rcnt == RCNT_LAST) begin
                        state_nxt = SCAN_HI;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + RW'(1);
                    end
                end
                SCAN_HI: begin
                    if (rcnt == RCNT_LAST) begin
                        state_nxt = SCAN_LO;
                        rcnt_nxt  = '0;
                        tick_nxt  = 1'b1;
                    end else begin
                        rcnt_nxt = rcnt + RW'(1);
                    end
                end
                default: begin
                    state_nxt = BLANK;
                    rcnt_nxt  = '0;
                end
            endcase
        end

        seg_true = lo_on ? digit_lo : (hi_on ? digit_hi : 7'h00);
        an_nxt   = {hi_on, lo_on} ^ AN_OFF;
        seg_nxt  = seg_true ^ SEG_OFF;
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: reset, capture, glitch rejection, scan,
// enable drop and mid-scan reset.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       lsb_in;
    logic       disp_en;
    logic [6:0] seg_out;
    logic [1:0] an_out;
    logic       frame_tick;
    logic       valid_out;
    logic [6:0] digit_lo;
    logic [6:0] digit_hi;

    int checks;
    int passes;
    int fails;

    seg_scan_ctrl #(
        .REFRESH_DIV  (8),
        .STABLE_CYCLES(4),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .lsb_in    (lsb_in),
        .disp_en   (disp_en),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .frame_tick(frame_tick),
        .valid_out (valid_out),
        .digit_lo  (digit_lo),
        .digit_hi  (digit_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, leaving time 1 unit after the last edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One comparison: count it, then assert equality
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Blank display expectations after the scan clock edge
    task automatic chk_off(input string tag);
        chk({tag, "_an"}, 8'(an_out), 8'h03);
        chk({tag, "_seg"}, 8'(seg_out), 8'h7F);
        chk({tag, "_tick"}, 8'(frame_tick), 8'h00);
    endtask

    initial begin
        int         p;
        logic [1:0] ea;
        logic [6:0] es;
        logic       et;

        checks  = 0;
        passes  = 0;
        fails   = 0;
        rst_n   = 1'b0;
        seg_in  = 7'h00;
        lsb_in  = 1'b0;
        disp_en = 1'b0;

        // Reset held for five edges
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_off("rst");
            chk("rst_valid", 8'(valid_out), 8'h00);
        end

        // Capture low digit 3F: sampled at edge 1, captured at edge 7
        rst_n  = 1'b1;
        seg_in = 7'h3F;
        lsb_in = 1'b1;
        tick(6);
        chk("lo_before", 8'(digit_lo), 8'h00);
        chk("valid_early", 8'(valid_out), 8'h00);
        tick(1);
        chk("lo_capt", 8'(digit_lo), 8'h3F);
        chk("hi_untouched", 8'(digit_hi), 8'h00);
        chk("valid_lo_only", 8'(valid_out), 8'h00);
        chk("an_disabled", 8'(an_out), 8'h03);
        tick(3);

        // Capture high digit 06: sampled at edge 11, captured at edge 17
        seg_in = 7'h06;
        lsb_in = 1'b0;
        tick(6);
        chk("hi_before", 8'(digit_hi), 8'h00);
        chk("valid_before", 8'(valid_out), 8'h00);
        tick(1);
        chk("hi_capt", 8'(digit_hi), 8'h06);
        chk("valid_set", 8'(valid_out), 8'h01);
        chk("lo_kept", 8'(digit_lo), 8'h3F);
        tick(3);

        // Glitching input, two cycles per value, never reaches stability
        lsb_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            seg_in = (i % 2 == 1) ? 7'h5B : 7'h3F;
            tick(2);
        end
        seg_in = 7'h3F;
        chk("glitch_lo", 8'(digit_lo), 8'h3F);
        tick(10);
        chk("glitch_lo_late", 8'(digit_lo), 8'h3F);
        chk("glitch_hi", 8'(digit_hi), 8'h06);
        chk("glitch_valid", 8'(valid_out), 8'h01);

        // Scan: off, lo x7, off, hi x7 with frame_tick every 16 cycles
        disp_en = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick(1);
            ea = 2'b11;
            es = 7'h7F;
            if (k >= 2) begin
                p = (k - 2) % 16;
                if (p >= 1 && p <= 7) begin
                    ea = 2'b10;
                    es = 7'h40;
                end else if (p >= 9) begin
                    ea = 2'b01;
                    es = 7'h79;
                end
            end
            et = (k >= 17) && ((k - 17) % 16 == 0);
            chk($sformatf("scan_an_k%0d", k), 8'(an_out), 8'(ea));
            chk($sformatf("scan_seg_k%0d", k), 8'(seg_out), 8'(es));
            chk($sformatf("scan_tick_k%0d", k), 8'(frame_tick), 8'(et));
        end

        // Drop enable at SCAN_HI terminal count: blank, no frame_tick
        disp_en = 1'b0;
        tick(1);
        chk_off("drop");
        tick(3);
        chk_off("drop_hold");

        // Re-enable: restart at SCAN_LO rcnt 0 with one dead cycle
        disp_en = 1'b1;
        tick(1);
        chk_off("re_1");
        tick(1);
        chk_off("re_2");
        tick(1);
        chk("re_lo_an", 8'(an_out), 8'h02);
        chk("re_lo_seg", 8'(seg_out), 8'h40);
        tick(6);
        chk("re_lo_last", 8'(an_out), 8'h02);
        tick(1);
        chk_off("re_dead_hi");

        // Reset during SCAN_LO with a new low pattern still in the filter
        tick(8);
        seg_in = 7'h66;
        lsb_in = 1'b1;
        tick(3);
        rst_n  = 1'b0;
        seg_in = 7'h00;
        lsb_in = 1'b0;
        tick(2);
        chk_off("mid_rst");
        chk("mid_rst_lo", 8'(digit_lo), 8'h00);
        chk("mid_rst_hi", 8'(digit_hi), 8'h00);
        chk("mid_rst_valid", 8'(valid_out), 8'h00);
        rst_n = 1'b1;
        tick(10);
        chk("post_rst_lo", 8'(digit_lo), 8'h00);
        chk("post_rst_valid", 8'(valid_out), 8'h00);
        chk("post_rst_an", 8'(an_out), 8'h03);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
